// File: rtl/usrt_pkg.sv
// Shared definitions for the APB-to-USRT bridge: register map, STATUS/CTRL
// bit positions, APB handshake states and the default FIFO depth.
package usrt_pkg;

  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

  localparam logic [7:0] ADDR_TXDATA = 8'h00;
  localparam logic [7:0] ADDR_RXDATA = 8'h04;
  localparam logic [7:0] ADDR_STATUS = 8'h08;
  localparam logic [7:0] ADDR_CTRL   = 8'h0C;

  localparam int unsigned ST_TX_FULL    = 0;
  localparam int unsigned ST_TX_EMPTY   = 1;
  localparam int unsigned ST_RX_EMPTY   = 2;
  localparam int unsigned ST_RX_FULL    = 3;
  localparam int unsigned ST_RX_OVERRUN = 4;

  localparam int unsigned CTRL_TX_EN  = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS,
    APB_DONE
  } apb_state_t;

endpackage

// File: rtl/usrt_fifo.sv
// Synchronous 8-bit FIFO; full/empty derive from the occupancy counter and
// the head entry is visible on rdata with no read latency (0 when empty).
module usrt_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     pClk,
  input  logic                     pReset,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [AW:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge pClk or posedge pReset) begin
    if (pReset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push & ~do_pop)      count <= count + CW'(1);
      else if (do_pop & ~do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/apb_usrt_bridge.sv
// APB slave exposing TX/RX byte FIFOs, STATUS and CTRL to a USRT serializer.
// Optional interrupt output is built when USRT_IRQ_EN is defined.
module apb_usrt_bridge
  import usrt_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic        pClk,
  input  logic        pReset,
  input  logic        pSelect,
  input  logic        pEnable,
  input  logic        pWrite,
  input  logic [31:0] pAddress,
  input  logic [7:0]  pWData,
  output logic [7:0]  pRData,
  output logic        pReady,
  output logic        pSlvErr,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
`ifdef USRT_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  apb_state_t    state, state_nxt;
  logic [7:0]    addr;
  logic          commit;
  logic          tx_en;
  logic          rx_overrun;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count;
  logic [7:0]    rx_head;
  logic          tx_push, tx_pop, rx_pop, ovr_set;
  logic [7:0]    status, ctrl_rd, acc_rdata;
  logic          acc_err, tx_wr, rx_rd, status_rd, ctrl_wr;
  logic          unused_bits;
`ifdef USRT_IRQ_EN
  logic          irq_en;
`endif

  assign addr        = pAddress[7:0];
  assign unused_bits = ^{pAddress[31:8], tx_count, rx_count};
  assign commit      = (state == APB_ACCESS);

  always_ff @(posedge pClk or posedge pReset) begin
    if (pReset) state <= APB_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      APB_IDLE:   if (pSelect & ~pEnable) state_nxt = APB_SETUP;
      APB_SETUP:  if (pEnable) state_nxt = APB_ACCESS;
                  else if (~pSelect) state_nxt = APB_IDLE;
      APB_ACCESS: state_nxt = APB_DONE;
      APB_DONE:   state_nxt = (pSelect & ~pEnable) ? APB_SETUP : APB_IDLE;
      default:    state_nxt = APB_IDLE;
    endcase
  end

  always_comb begin
    status = '0;
    status[ST_TX_FULL]    = tx_full;
    status[ST_TX_EMPTY]   = tx_empty;
    status[ST_RX_EMPTY]   = rx_empty;
    status[ST_RX_FULL]    = rx_full;
    status[ST_RX_OVERRUN] = rx_overrun;
    ctrl_rd = '0;
    ctrl_rd[CTRL_TX_EN] = tx_en;
`ifdef USRT_IRQ_EN
    ctrl_rd[CTRL_IRQ_EN] = irq_en;
`else
    ctrl_rd[CTRL_IRQ_EN] = 1'b0;
`endif
  end

  assign tx_valid = ~tx_empty & tx_en;
  assign tx_pop   = tx_valid & tx_ready;

  // Address decode; effects are applied only when commit is high.
  always_comb begin
    acc_rdata = '0;
    acc_err   = 1'b0;
    tx_wr     = 1'b0;
    rx_rd     = 1'b0;
    status_rd = 1'b0;
    ctrl_wr   = 1'b0;
    case (addr)
      ADDR_TXDATA: if (pWrite) begin
                     tx_wr   = 1'b1;
                     acc_err = tx_full & ~tx_pop;
                   end else acc_err = 1'b1;
      ADDR_RXDATA: if (!pWrite) begin
                     rx_rd     = ~rx_empty;
                     acc_rdata = rx_head;
                   end else acc_err = 1'b1;
      ADDR_STATUS: if (!pWrite) begin
                     status_rd = 1'b1;
                     acc_rdata = status;
                   end else acc_err = 1'b1;
      ADDR_CTRL:   if (pWrite) ctrl_wr = 1'b1;
                   else        acc_rdata = ctrl_rd;
      default:     acc_err = 1'b1;
    endcase
  end

  assign tx_push = commit & tx_wr & ~acc_err;
  assign rx_pop  = commit & rx_rd;
  assign ovr_set = rx_valid & rx_full & ~rx_pop;

  usrt_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .pClk(pClk), .pReset(pReset), .push(tx_push), .wdata(pWData), .pop(tx_pop),
    .rdata(tx_data), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  usrt_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .pClk(pClk), .pReset(pReset), .push(rx_valid), .wdata(rx_data), .pop(rx_pop),
    .rdata(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  always_ff @(posedge pClk or posedge pReset) begin
    if (pReset) begin
      pReady     <= 1'b0;
      pRData     <= '0;
      pSlvErr    <= 1'b0;
      tx_en      <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      pReady  <= commit;
      pRData  <= commit ? acc_rdata : '0;
      pSlvErr <= commit & acc_err;
      if (commit & ctrl_wr) tx_en <= pWData[CTRL_TX_EN];
      // A fresh overrun in the clearing cycle takes priority over the clear.
      if (ovr_set)                     rx_overrun <= 1'b1;
      else if (commit & status_rd)     rx_overrun <= 1'b0;
    end
  end

`ifdef USRT_IRQ_EN
  always_ff @(posedge pClk or posedge pReset) begin
    if (pReset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (commit & ctrl_wr) irq_en <= pWData[CTRL_IRQ_EN];
      irq <= irq_en & (~rx_empty | (tx_empty & tx_en) | rx_overrun);
    end
  end
`endif

endmodule

// File: tb/tb_apb_usrt_bridge.sv
// Self-checking bench for apb_usrt_bridge (default build, FIFO_DEPTH=4):
// directed vector table, hand-written corner sequences, randomized queue model.
module tb_apb_usrt_bridge;

  localparam int DEPTH = 4;

  logic        pClk, pReset, pSelect, pEnable, pWrite;
  logic [31:0] pAddress;
  logic [7:0]  pWData, pRData, tx_data, rx_data;
  logic        pReady, pSlvErr, tx_valid, tx_ready, rx_valid;
`ifdef USRT_IRQ_EN
  logic        irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  apb_usrt_bridge #(.FIFO_DEPTH(DEPTH)) dut (
    .pClk(pClk), .pReset(pReset), .pSelect(pSelect), .pEnable(pEnable),
    .pWrite(pWrite), .pAddress(pAddress), .pWData(pWData), .pRData(pRData),
    .pReady(pReady), .pSlvErr(pSlvErr), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid)
`ifdef USRT_IRQ_EN
    , .irq(irq)
`endif
  );

  initial pClk = 1'b0;
  always #5 pClk = ~pClk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model state
  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  bit         m_txen;
  bit         m_ovr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    pReset = 1'b1; pSelect = 0; pEnable = 0; pWrite = 0; pAddress = '0; pWData = '0;
    tx_ready = 0; rx_valid = 0; rx_data = '0;
    @(posedge pClk); #1;
    pReset = 1'b0;
    @(posedge pClk); #1;
    m_tx.delete(); m_rx.delete(); m_txen = 0; m_ovr = 0;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    @(posedge pClk); #1;
    rx_valid = 1'b0;
  endtask

  // One APB transfer; rx/tx pulses (if requested) are presented in the commit cycle.
  task automatic apb(input bit wr, input logic [31:0] a, input logic [7:0] wd,
                     input bit rxp, input logic [7:0] rxb, input bit txp,
                     output logic [7:0] rd, output logic err);
    int waits;
    pSelect = 1; pEnable = 0; pWrite = wr; pAddress = a; pWData = wd;
    @(posedge pClk); #1;
    pEnable = 1; waits = 0;
    while (!pReady && waits < 8) begin
      @(posedge pClk); #1;
      waits++;
      rx_valid = 0; tx_ready = 0;
      if (waits == 1) begin
        rx_valid = rxp; rx_data = rxb; tx_ready = txp;
      end
    end
    rd = pRData; err = pSlvErr;
    check("wait_states", waits, 2);
    pSelect = 0; pEnable = 0; rx_valid = 0; tx_ready = 0;
    @(posedge pClk); #1;
    check("ready_drop", {pReady, pSlvErr, pRData}, 0);
  endtask

  // Queue-based model of one transfer's register effects.
  task automatic model_xfer(input bit wr, input logic [31:0] a, input logic [7:0] wd,
                            input bit rxp, input logic [7:0] rxb, input bit txp,
                            output logic [7:0] erd, output logic eerr);
    bit tx_out, push_tx, pop_rx, clr, new_en;
    erd = 0; eerr = 0; push_tx = 0; pop_rx = 0; clr = 0; new_en = m_txen;
    tx_out = txp && m_txen && (m_tx.size() > 0);
    case (a[7:0])
      8'h00: if (wr) begin
               if (m_tx.size() == DEPTH && !tx_out) eerr = 1; else push_tx = 1;
             end else eerr = 1;
      8'h04: if (!wr) begin
               if (m_rx.size() > 0) begin erd = m_rx[0]; pop_rx = 1; end
             end else eerr = 1;
      8'h08: if (!wr) begin
               erd = {3'b000, m_ovr, m_rx.size() == DEPTH, m_rx.size() == 0,
                      m_tx.size() == 0, m_tx.size() == DEPTH};
               clr = 1;
             end else eerr = 1;
      8'h0C: if (wr) new_en = wd[0]; else erd = {7'b0, m_txen};
      default: eerr = 1;
    endcase
    if (tx_out)  void'(m_tx.pop_front());
    if (push_tx) m_tx.push_back(wd);
    if (pop_rx)  void'(m_rx.pop_front());
    if (clr)     m_ovr = 0;
    if (rxp) begin
      if (m_rx.size() == DEPTH) m_ovr = 1; else m_rx.push_back(rxb);
    end
    m_txen = new_en;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  wd;
    bit          txp;
    logic [7:0]  rd;
    bit          err;
    bit          txv;
    logic [7:0]  txd;
  } vec_t;

  vec_t tbl[17];

  initial begin
    logic [7:0] rd, erd;
    logic       err, eerr;
    logic [7:0] got[$];

    tbl[0]  = '{1, 32'h00,        8'h41, 0, 8'h00, 0, 0, 8'h41};
    tbl[1]  = '{1, 32'h0C,        8'h01, 0, 8'h00, 0, 1, 8'h41};
    tbl[2]  = '{0, 32'h0C,        8'h00, 0, 8'h01, 0, 1, 8'h41};
    tbl[3]  = '{0, 32'h0C,        8'h00, 1, 8'h01, 0, 0, 8'h00};
    tbl[4]  = '{0, 32'h08,        8'h00, 0, 8'h06, 0, 0, 8'h00};
    tbl[5]  = '{0, 32'h10,        8'h00, 0, 8'h00, 1, 0, 8'h00};
    tbl[6]  = '{1, 32'h08,        8'hFF, 0, 8'h00, 1, 0, 8'h00};
    tbl[7]  = '{0, 32'h00,        8'h00, 0, 8'h00, 1, 0, 8'h00};
    tbl[8]  = '{1, 32'h04,        8'h33, 0, 8'h00, 1, 0, 8'h00};
    tbl[9]  = '{0, 32'h0C,        8'h00, 0, 8'h01, 0, 0, 8'h00};
    tbl[10] = '{0, 32'h08,        8'h00, 0, 8'h06, 0, 0, 8'h00};
    tbl[11] = '{0, 32'h04,        8'h00, 0, 8'h00, 0, 0, 8'h00};
    tbl[12] = '{0, 32'h0000_0108, 8'h00, 0, 8'h06, 0, 0, 8'h00};
    tbl[13] = '{1, 32'h0C,        8'h00, 0, 8'h00, 0, 0, 8'h00};
    tbl[14] = '{0, 32'h0C,        8'h00, 0, 8'h00, 0, 0, 8'h00};
    tbl[15] = '{1, 32'hFFFF_FF00, 8'h99, 0, 8'h00, 0, 0, 8'h99};
    tbl[16] = '{0, 32'h08,        8'h00, 0, 8'h04, 0, 0, 8'h99};

    // Reset values, sampled while reset is still asserted
    pReset = 1; pSelect = 0; pEnable = 0; pWrite = 0; pAddress = '0; pWData = '0;
    tx_ready = 0; rx_valid = 0; rx_data = '0;
    #2;
    check("reset_outputs", {pReady, pSlvErr, pRData, tx_valid, tx_data}, 0);
    do_reset();

    // Directed register-map table
    for (int i = 0; i < 17; i++) begin
      apb(tbl[i].wr, tbl[i].addr, tbl[i].wd, 0, 8'h00, tbl[i].txp, rd, err);
      check($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
      check($sformatf("tbl%0d_slverr", i), err, tbl[i].err);
      check($sformatf("tbl%0d_tx_valid", i), tx_valid, tbl[i].txv);
      check($sformatf("tbl%0d_tx_data", i), tx_data, tbl[i].txd);
    end

    // TX FIFO overflow with tx_en=0, then in-order drain
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apb(1, 32'h00, 8'h10 + 8'(i), 0, 8'h00, 0, rd, err);
      check($sformatf("txfill%0d_slverr", i), err, (i == 4) ? 1 : 0);
    end
    check("txfill_frozen_valid", tx_valid, 0);
    apb(0, 32'h08, 8'h00, 0, 8'h00, 0, rd, err);
    check("txfill_status", rd, 8'h05);
    apb(1, 32'h0C, 8'h01, 0, 8'h00, 0, rd, err);
    tx_ready = 1;
    for (int c = 0; c < 20 && got.size() < 4; c++) begin
      if (tx_valid) got.push_back(tx_data);
      @(posedge pClk); #1;
    end
    tx_ready = 0;
    check("txdrain_count", got.size(), 4);
    for (int i = 0; i < got.size(); i++)
      check($sformatf("txdrain%0d", i), got[i], 8'h10 + 8'(i));
    check("txdrain_empty", tx_valid, 0);

    // RX overflow sets sticky overrun; STATUS read clears it
    do_reset();
    for (int i = 0; i < 5; i++) rx_pulse(8'hA0 + 8'(i));
    apb(0, 32'h08, 8'h00, 0, 8'h00, 0, rd, err);
    check("rxovr_status1", rd, 8'h1A);
    apb(0, 32'h08, 8'h00, 0, 8'h00, 0, rd, err);
    check("rxovr_status2", rd, 8'h0A);
    for (int i = 0; i < 5; i++) begin
      apb(0, 32'h04, 8'h00, 0, 8'h00, 0, rd, err);
      check($sformatf("rxread%0d_data", i), rd, (i == 4) ? 8'h00 : 8'hA0 + 8'(i));
      check($sformatf("rxread%0d_slverr", i), err, 0);
    end

    // RX full: push coinciding with RXDATA pop is accepted
    do_reset();
    for (int i = 0; i < 4; i++) rx_pulse(8'hB0 + 8'(i));
    apb(0, 32'h04, 8'h00, 1, 8'h55, 0, rd, err);
    check("rxswap_data", rd, 8'hB0);
    apb(0, 32'h08, 8'h00, 0, 8'h00, 0, rd, err);
    check("rxswap_status", rd, 8'h0A);
    for (int i = 0; i < 4; i++) begin
      apb(0, 32'h04, 8'h00, 0, 8'h00, 0, rd, err);
      check($sformatf("rxswap_read%0d", i), rd, (i == 3) ? 8'h55 : 8'hB1 + 8'(i));
    end

    // New overrun in the STATUS clearing cycle keeps the bit set
    do_reset();
    for (int i = 0; i < 5; i++) rx_pulse(8'hC0 + 8'(i));
    apb(0, 32'h08, 8'h00, 1, 8'h66, 0, rd, err);
    check("ovrwin_status1", rd, 8'h1A);
    apb(0, 32'h08, 8'h00, 0, 8'h00, 0, rd, err);
    check("ovrwin_status2", rd, 8'h1A);
    apb(0, 32'h08, 8'h00, 0, 8'h00, 0, rd, err);
    check("ovrwin_status3", rd, 8'h0A);

    // TX full: write accepted when the serializer pops in the commit cycle
    do_reset();
    apb(1, 32'h0C, 8'h01, 0, 8'h00, 0, rd, err);
    for (int i = 0; i < 4; i++) apb(1, 32'h00, 8'h01 + 8'(i), 0, 8'h00, 0, rd, err);
    apb(1, 32'h00, 8'h05, 0, 8'h00, 1, rd, err);
    check("txswap_slverr", err, 0);
    check("txswap_head", tx_data, 8'h02);
    apb(0, 32'h08, 8'h00, 0, 8'h00, 0, rd, err);
    check("txswap_status", rd, 8'h05);

    // Reset during ACCESS of a TXDATA write aborts it
    do_reset();
    pSelect = 1; pEnable = 0; pWrite = 1; pAddress = 32'h00; pWData = 8'h77;
    @(posedge pClk); #1;
    pEnable = 1;
    @(posedge pClk); #1;
    pReset = 1;
    #1;
    check("abort_async_ready", {pReady, pSlvErr}, 0);
    @(posedge pClk); #1;
    pReset = 0; pSelect = 0; pEnable = 0;
    @(posedge pClk); #1;
    apb(0, 32'h08, 8'h00, 0, 8'h00, 0, rd, err);
    check("abort_status", rd, 8'h06);
    check("abort_tx_data", tx_data, 8'h00);

    // Randomized traffic against the queue model
    do_reset();
    for (int n = 0; n < 200; n++) begin
      bit          wr, rxp, txp;
      logic [31:0] a;
      logic [7:0]  wd, rxb;
      int          sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: a = 32'h00;
        3, 4:    a = 32'h04;
        5:       a = 32'h08;
        6:       a = 32'h0C;
        7:       a = {$urandom_range(0, 255), 24'h0} | 32'h04;
        default: a = 32'h10 + 32'($urandom_range(0, 200));
      endcase
      wr  = (sel == 0 || sel == 1 || sel == 2) ? ($urandom_range(0, 7) != 0) : $urandom_range(0, 1);
      wd  = 8'($urandom());
      rxp = ($urandom_range(0, 2) == 0);
      rxb = 8'($urandom());
      txp = ($urandom_range(0, 2) == 0);
      model_xfer(wr, a, wd, rxp, rxb, txp, erd, eerr);
      apb(wr, a, wd, rxp, rxb, txp, rd, err);
      check($sformatf("rnd%0d_rdata", n), rd, erd);
      check($sformatf("rnd%0d_slverr", n), err, eerr);
      check($sformatf("rnd%0d_tx_valid", n), tx_valid, m_txen && m_tx.size() > 0);
      check($sformatf("rnd%0d_tx_data", n), tx_data, (m_tx.size() > 0) ? m_tx[0] : 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
